pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
// - Holds the architectural PC and fetches one instruction at a time from instruction memory.
// - Presents the fetched {pc, inst} pair to decode/execute over a valid/ready handshake.
// - Loads the next PC from the next-PC stage (npc) when the current instruction commits.
// - Sits directly upstream of the next-PC logic: its pc output feeds the PC input there,
//   and it consumes the npc result.
// PARAMETERS
// - RESET_PC   32'h0000_0000   PC value loaded on reset; first fetch address
// - CNT_W      32              width of the retired-instruction counter
// PORTS
// - clk         in   1      clock, rising edge
// - rst_n       in   1      asynchronous reset, active low
// - npc         in   32     next PC from the next-PC stage
// - npc_we      in   1      commit strobe: the current instruction retires; load npc
// - imem_req    out  1      fetch request to instruction memory
// - imem_addr   out  32     fetch address; equals pc
// - imem_gnt    in   1      memory accepts the request this cycle
// - imem_rvalid in   1      read data valid; earliest one cycle after gnt
// - imem_rdata  in   32     instruction word
// - inst_valid  out  1      {pc, inst} valid to downstream
// - inst_ready  in   1      downstream accepts {pc, inst}
// - inst        out  32     fetched instruction (registered)
// - pc          out  32     PC of inst; current architectural PC
// - fetch_err   out  1      sticky flag: misaligned npc was committed
// - instr_cnt   out  CNT_W  retired-instruction count
// BEHAVIOUR
// - Reset (async, while rst_n=0) forces the following values:
//   - state=BOOT, pc=RESET_PC, inst=0, instr_cnt=0
//   - imem_req=0, inst_valid=0, fetch_err=0
// - FSM states: BOOT, REQ, WAIT, HOLD, EXEC, ERR. Only one fetch is outstanding at a time.
//   - BOOT: outputs idle. Next clock -> REQ.
//   - REQ: imem_req=1, imem_addr=pc. If imem_gnt -> WAIT; else stay, with addr held stable.
//   - WAIT: imem_req=0. If imem_rvalid: inst<=imem_rdata -> HOLD.
//   - HOLD: inst_valid=1; pc and inst held stable until the handshake.
//     - inst_valid & inst_ready -> EXEC.
//     - Same cycle as the handshake with npc_we=1: commit immediately (rule below), bypassing EXEC.
//   - EXEC: inst_valid=0. Wait for npc_we; on npc_we, commit.
//   - Commit:
//     - If npc[1:0]==2'b00: pc<=npc, instr_cnt<=instr_cnt+1 (wraps mod 2^CNT_W), -> REQ.
//     - Else: -> ERR; pc unchanged, instr_cnt unchanged.
//   - ERR: fetch_err=1, imem_req=0, inst_valid=0. Left only by reset.
// - Ignored inputs:
//   - imem_rvalid outside WAIT.
//   - npc_we in BOOT, REQ, WAIT, ERR, and in HOLD without the handshake.
//   - imem_gnt outside REQ.
// - Minimum commit-to-commit latency with gnt in REQ and rvalid on the next cycle:
//   - REQ (1 cycle) + WAIT (1 cycle) + HOLD with ready and npc_we = 3 cycles.
// - All outputs are registered or decoded from state only. No input-to-output combinational path.
// - Reset mid-operation drops any outstanding fetch. Instruction memory shares rst_n.
// - Handshake rule: once inst_valid=1 it stays 1, with inst and pc stable, until inst_ready=1.
// TESTING
// - Reset: hold rst_n=0 -> pc=RESET_PC, imem_req=0, inst_valid=0, fetch_err=0, instr_cnt=0.
//   Release rst_n -> one BOOT cycle, then imem_req=1, imem_addr=0x0.
// - Basic fetch: gnt in REQ, rvalid next cycle with rdata=0x00500093
//   -> inst_valid=1, inst=0x00500093, pc=0x0.
// - Backpressure: inst_ready=0 for 5 cycles -> inst_valid, inst, pc stable.
//   Then inst_ready=1, npc_we=1, npc=0x4 in one cycle -> next cycle imem_req=1, addr=0x4, instr_cnt=1.
// - Grant stall: imem_gnt=0 for 3 cycles with a spurious rvalid (rdata=0xDEADBEEF) in REQ
//   -> req/addr held, inst unchanged. gnt=1 -> WAIT.
// - Misaligned commit: npc=0x6 with npc_we in EXEC -> fetch_err=1, imem_req=0 permanently,
//   pc unchanged, instr_cnt unchanged, until reset.
// - Async reset in WAIT, between clock edges -> all outputs reach reset values before the next edge.
//   A late rvalid after release is ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC, fetches one instruction at a time and
// hands {pc, inst} downstream over valid/ready, reloading pc from npc on commit.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      npc,
  input  logic             npc_we,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [2:0] BOOT = 3'd0, REQ = 3'd1, WAIT = 3'd2, HOLD = 3'd3, EXEC = 3'd4, ERR = 3'd5;
  logic [2:0] state, state_n;
  logic commit, aligned;
  assign commit     = npc_we & ((state == HOLD & inst_ready) | state == EXEC);
  assign aligned    = npc[1:0] == 2'b00;
  assign imem_req   = state == REQ;
  assign imem_addr  = pc;
  assign inst_valid = state == HOLD;
  assign fetch_err  = state == ERR;
  // commit takes priority so a HOLD handshake with npc_we skips EXEC
  always_comb
    state_n = commit             ? (aligned ? REQ : ERR) :
              state == BOOT      ? REQ :
              state == REQ       ? (imem_gnt ? WAIT : REQ) :
              state == WAIT      ? (imem_rvalid ? HOLD : WAIT) :
              state == HOLD      ? (inst_ready ? EXEC : HOLD) :
              state == EXEC      ? EXEC : ERR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      inst      <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT && imem_rvalid) inst <= imem_rdata;
      if (commit && aligned) begin
        pc        <= npc;
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven fetch/commit vectors with a {pc, inst} scoreboard,
// plus directed sequences for misaligned commit and async reset mid-fetch.
module tb_pc_fetch_unit;
  logic        clk = 0, rst_n = 0;
  logic [31:0] npc = 0, imem_addr, imem_rdata = 0, inst, pc;
  logic        npc_we = 0, imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic        inst_valid, inst_ready = 0, fetch_err;
  logic [31:0] instr_cnt;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .npc_we(npc_we),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .fetch_err(fetch_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] rdata; logic [31:0] nx; int hold; bit via_exec; int gstall; } vec_t;
  exp_t q[$];
  vec_t vecs[$];
  int passed = 0, total = 0;
  logic [31:0] m_pc = 0, m_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] rd, input logic [31:0] nx, input int hold,
                          input bit via_exec, input int gstall);
    logic [31:0] inst0;
    exp_t e;
    int n;
    chk("req_in_req", imem_req, 1);
    chk("addr_in_req", imem_addr, m_pc);
    inst0 = inst;
    imem_rvalid = gstall > 0;
    imem_rdata  = 32'hDEADBEEF;
    for (int i = 0; i < gstall; i++) begin
      cyc();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, m_pc);
      chk("stall_inst", inst, inst0);
    end
    imem_rvalid = 0;
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    chk("wait_req", imem_req, 0);
    imem_rvalid = 1;
    imem_rdata  = rd;
    q.push_back('{m_pc, rd});
    cyc();
    imem_rvalid = 0;
    n = 0;
    while (!inst_valid && n < 8) begin
      cyc();
      n++;
    end
    chk("inst_valid", inst_valid, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_inst", inst, e.inst);
    end
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("bp_valid", inst_valid, 1);
      chk("bp_inst", inst, rd);
      chk("bp_pc", pc, m_pc);
    end
    inst_ready = 1;
    if (via_exec) begin
      cyc();
      inst_ready = 0;
      chk("exec_valid", inst_valid, 0);
      chk("exec_req", imem_req, 0);
      npc_we = 1;
      npc = nx;
      cyc();
    end else begin
      npc_we = 1;
      npc = nx;
      cyc();
    end
    inst_ready = 0;
    npc_we = 0;
    if (nx[1:0] == 2'b00) begin
      m_pc = nx;
      m_cnt++;
      chk("commit_req", imem_req, 1);
      chk("commit_addr", imem_addr, nx);
      chk("commit_cnt", instr_cnt, m_cnt);
      chk("commit_err", fetch_err, 0);
    end else begin
      chk("mis_err", fetch_err, 1);
      chk("mis_req", imem_req, 0);
      chk("mis_pc", pc, m_pc);
      chk("mis_cnt", instr_cnt, m_cnt);
      chk("mis_valid", inst_valid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{32'h00500093, 32'h0000_0004, 5, 1'b0, 0});
    vecs.push_back('{32'h00a00113, 32'h0000_0008, 0, 1'b1, 3});
    vecs.push_back('{32'h002081b3, 32'h0000_0100, 2, 1'b0, 0});
    vecs.push_back('{32'h12345678, 32'hFFFF_FFFC, 0, 1'b1, 1});
    vecs.push_back('{32'h00000000, 32'h0000_0000, 1, 1'b0, 0});

    cyc();
    cyc();
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_inst", inst, 0);
    rst_n = 1;
    chk("boot_req", imem_req, 0);
    cyc();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);

    foreach (vecs[i]) do_fetch(vecs[i].rdata, vecs[i].nx, vecs[i].hold, vecs[i].via_exec, vecs[i].gstall);

    do_fetch(32'h00000013, 32'h0000_0006, 0, 1'b1, 0);
    npc_we = 1;
    npc = 32'h10;
    imem_gnt = 1;
    imem_rvalid = 1;
    inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("err_sticky", fetch_err, 1);
      chk("err_req", imem_req, 0);
      chk("err_pc", pc, m_pc);
      chk("err_cnt", instr_cnt, m_cnt);
    end
    npc_we = 0;
    imem_gnt = 0;
    imem_rvalid = 0;
    inst_ready = 0;

    rst_n = 0;
    #1;
    chk("rst2_err", fetch_err, 0);
    chk("rst2_pc", pc, 0);
    cyc();
    rst_n = 1;
    m_pc = 0;
    m_cnt = 0;
    cyc();
    do_fetch(32'h00100093, 32'h0000_0040, 0, 1'b0, 0);
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    chk("wait2_req", imem_req, 0);
    #3;
    rst_n = 0;
    #1;
    chk("async_pc", pc, 0);
    chk("async_cnt", instr_cnt, 0);
    chk("async_req", imem_req, 0);
    chk("async_valid", inst_valid, 0);
    chk("async_err", fetch_err, 0);
    chk("async_inst", inst, 0);
    cyc();
    rst_n = 1;
    imem_rvalid = 1;
    imem_rdata = 32'h0BAD0BAD;
    cyc();
    chk("late_inst", inst, 0);
    chk("late_valid", inst_valid, 0);
    chk("late_req", imem_req, 1);
    chk("late_addr", imem_addr, 0);
    cyc();
    chk("late_inst2", inst, 0);
    imem_rvalid = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
